// File: rtl/key_event_scheduler.sv
// Two-key event scheduler: per-key press/long/repeat/release FSMs feed one-deep
// pending slots, which a fixed-priority arbiter drains into a 4-entry event FIFO.
module key_event_scheduler #(
    parameter int unsigned LONG_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic       sysClk,
    input  logic       sysRst,
    input  logic [1:0] stableKey,
    input  logic       evtReady,
    output logic       evtValid,
    output logic       evtKey,
    output logic [1:0] evtType,
    output logic       overflow
);

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

    localparam logic [1:0]  EV_PRESS   = 2'b00;
    localparam logic [1:0]  EV_LONG    = 2'b01;
    localparam logic [1:0]  EV_REPEAT  = 2'b10;
    localparam logic [1:0]  EV_RELEASE = 2'b11;
    localparam logic [31:0] LONG_LAST  = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] REP_LAST   = 32'(REPEAT_CYCLES - 1);

    state_t      state_q [2];
    state_t      state_d [2];
    logic [31:0] cnt_q   [2];
    logic [31:0] cnt_d   [2];
    logic [1:0]  keyPrev_q;
    logic [1:0]  pressEdge, relEdge;
    logic [1:0]  post;
    logic [1:0]  postType [2];

    logic [1:0]  slotV_q, slotV_d;
    logic [1:0]  slotT_q [2];
    logic [1:0]  slotT_d [2];
    logic [1:0]  grant;
    logic        room, push, pop, drop;
    logic [2:0]  pushData;

    logic [2:0]  fifoMem_q [4];
    logic [1:0]  wptr_q, rptr_q;
    logic [2:0]  count_q;
    logic        overflow_q;
    logic [2:0]  head;

    assign pressEdge = stableKey & ~keyPrev_q;
    assign relEdge   = ~stableKey & keyPrev_q;

    // Release is checked first so it suppresses a long/repeat due on the same edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            post[i]     = 1'b0;
            postType[i] = EV_PRESS;
            case (state_q[i])
                S_IDLE: begin
                    if (pressEdge[i]) begin
                        state_d[i]  = S_PRESSED;
                        cnt_d[i]    = '0;
                        post[i]     = 1'b1;
                        postType[i] = EV_PRESS;
                    end
                end
                S_PRESSED, S_HELD: begin
                    if (relEdge[i]) begin
                        state_d[i]  = S_IDLE;
                        cnt_d[i]    = '0;
                        post[i]     = 1'b1;
                        postType[i] = EV_RELEASE;
                    end else if (state_q[i] == S_PRESSED && cnt_q[i] == LONG_LAST) begin
                        state_d[i]  = S_HELD;
                        cnt_d[i]    = '0;
                        post[i]     = 1'b1;
                        postType[i] = EV_LONG;
                    end else if (state_q[i] == S_HELD && cnt_q[i] == REP_LAST) begin
                        cnt_d[i]    = '0;
                        post[i]     = 1'b1;
                        postType[i] = EV_REPEAT;
                    end else begin
                        cnt_d[i]    = cnt_q[i] + 32'd1;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // A pop on the same edge frees the full FIFO's last entry, so a push may proceed.
    assign pop      = evtValid & evtReady;
    assign room     = (count_q != 3'd4) | pop;
    assign grant[0] = slotV_q[0] & room;
    assign grant[1] = slotV_q[1] & ~slotV_q[0] & room;
    assign push     = |grant;
    assign pushData = grant[0] ? {1'b0, slotT_q[0]} : {1'b1, slotT_q[1]};
    assign drop     = |(post & slotV_q & ~grant);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slotV_d[i] = slotV_q[i] & ~grant[i];
            slotT_d[i] = slotT_q[i];
            if (post[i] && (!slotV_q[i] || grant[i])) begin
                slotV_d[i] = 1'b1;
                slotT_d[i] = postType[i];
            end
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            keyPrev_q  <= 2'b00;
            slotV_q    <= 2'b00;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                slotT_q[i] <= EV_PRESS;
            end
        end else begin
            keyPrev_q <= stableKey;
            slotV_q   <= slotV_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                slotT_q[i] <= slotT_d[i];
            end
            if (push) wptr_q <= wptr_q + 2'd1;
            if (pop)  rptr_q <= rptr_q + 2'd1;
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge sysClk) begin
        if (push) fifoMem_q[wptr_q] <= pushData;
    end

    assign head     = fifoMem_q[rptr_q];
    assign evtValid = (count_q != 3'd0);
    assign evtKey   = evtValid & head[2];
    assign evtType  = evtValid ? head[1:0] : 2'b00;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: directed scenarios plus random key/ready traffic,
// all checked against an event-timing reference model.
module tb_key_event_scheduler;

    localparam int L = 8;
    localparam int R = 4;

    logic       sysClk = 1'b0;
    logic       sysRst;
    logic [1:0] stableKey;
    logic       evtReady;
    logic       evtValid, evtKey, overflow;
    logic [1:0] evtType;

    key_event_scheduler #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
        .sysClk(sysClk), .sysRst(sysRst), .stableKey(stableKey), .evtReady(evtReady),
        .evtValid(evtValid), .evtKey(evtKey), .evtType(evtType), .overflow(overflow)
    );

    always #5 sysClk = ~sysClk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    // Reference model: events are derived from press times (long at press+L,
    // repeat at press+L+n*R), then pass through one-deep slots and a 4-deep queue.
    bit         mPrev [2];
    bit         mAct  [2];
    int         mPt   [2];
    bit         mSv   [2];
    logic [2:0] mSe   [2];
    logic [2:0] mQ    [$];
    bit         mOvf;
    int         cyc = 0;
    int         tally [8];  // DUT-accepted events, index key*4+type

    task automatic model_edge();
        bit         pop, room, has;
        int         g;
        logic [2:0] gv, ev;
        cyc++;
        if (sysRst) begin
            mQ.delete();
            mOvf = 0;
            for (int i = 0; i < 2; i++) begin
                mPrev[i] = 0; mAct[i] = 0; mSv[i] = 0;
            end
            return;
        end
        pop  = (mQ.size() != 0) && evtReady;
        room = (mQ.size() < 4) || pop;
        g = -1;
        if (mSv[0] && room) g = 0;
        else if (mSv[1] && room) g = 1;
        gv = (g >= 0) ? mSe[g] : 3'd0;
        for (int i = 0; i < 2; i++) begin
            has = 0;
            ev  = 3'(i * 4);
            if (stableKey[i] && !mPrev[i]) begin
                has = 1; mAct[i] = 1; mPt[i] = cyc;
            end else if (!stableKey[i] && mPrev[i]) begin
                has = 1; ev = ev | 3'd3; mAct[i] = 0;
            end else if (stableKey[i] && mAct[i]) begin
                int d;
                d = cyc - mPt[i];
                if (d == L) begin has = 1; ev = ev | 3'd1; end
                else if (d > L && (d - L) % R == 0) begin has = 1; ev = ev | 3'd2; end
            end
            if (has) begin
                if (mSv[i] && g != i) mOvf = 1;
                else begin mSv[i] = 1; mSe[i] = ev; end
            end else if (g == i) mSv[i] = 0;
            mPrev[i] = stableKey[i];
        end
        if (pop) void'(mQ.pop_front());
        if (g >= 0) mQ.push_back(gv);
    endtask

    task automatic step();
        if (evtValid === 1'b1 && evtReady) tally[{evtKey, evtType}]++;
        @(posedge sysClk);
        model_edge();
        #1;
        chk("valid", evtValid, mQ.size() != 0);
        chk("key",   evtKey,   mQ.size() != 0 ? mQ[0][2] : 1'b0);
        chk("type",  evtType,  mQ.size() != 0 ? mQ[0][1:0] : 2'b00);
        chk("ovf",   overflow, mOvf);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_tally();
        for (int i = 0; i < 8; i++) tally[i] = 0;
    endtask

    initial begin
        sysRst = 1'b1; stableKey = 2'b00; evtReady = 1'b1;
        clr_tally();
        steps(2);
        sysRst = 1'b0;
        chk("rst_valid", evtValid, 0);
        chk("rst_key", evtKey, 0);
        chk("rst_type", evtType, 0);
        chk("rst_ovf", overflow, 0);

        // short press on key 0: press then release, no long
        clr_tally();
        stableKey = 2'b01; steps(3);
        stableKey = 2'b00; steps(6);
        chk("s1_press", tally[0], 1);
        chk("s1_long", tally[1], 0);
        chk("s1_rel", tally[3], 1);
        chk("s1_ovf", overflow, 0);

        // key 1 held 20 cycles: press, long, two repeats, release
        clr_tally();
        stableKey = 2'b10; steps(20);
        stableKey = 2'b00; steps(6);
        chk("s2_press", tally[4], 1);
        chk("s2_long", tally[5], 1);
        chk("s2_rep", tally[6], 2);
        chk("s2_rel", tally[7], 1);

        // simultaneous rise: key 0 first, key 1 one edge later
        stableKey = 2'b11; step();
        step();
        chk("s3_k0", {evtValid, evtKey, evtType}, 4'b1000);
        step();
        chk("s3_k1", {evtValid, evtKey, evtType}, 4'b1100);
        stableKey = 2'b00; steps(8);

        // stalled consumer: 4 in FIFO, 1 in slot, 6th dropped
        clr_tally();
        evtReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stableKey[0] = ~stableKey[0];
            step();
        end
        steps(2);
        chk("s4_valid", evtValid, 1);
        chk("s4_ovf", overflow, 1);
        evtReady = 1'b1;
        steps(8);
        chk("s4_press", tally[0], 3);
        chk("s4_rel", tally[3], 2);
        chk("s4_empty", evtValid, 0);

        // reset while held: clears everything, then a fresh press
        stableKey = 2'b01; steps(10);
        sysRst = 1'b1; step();
        sysRst = 1'b0;
        chk("s5_valid", evtValid, 0);
        chk("s5_ovf", overflow, 0);
        steps(2);
        chk("s5_press", {evtValid, evtKey, evtType}, 4'b1000);
        stableKey = 2'b00; steps(4);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 9) == 0) stableKey[i] = ~stableKey[i];
            evtReady = ($urandom_range(0, 9) < 6);
            sysRst   = ($urandom_range(0, 599) == 0);
            step();
        end
        sysRst = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/key_event_scheduler.md
KEY_EVENT_SCHEDULER -- requirements
Module: key_event_scheduler

Interface
REQ-001 Parameter LONG_CYCLES, default 50000000, hold cycles from press to long-press event (1 s at 50 MHz); legal range 2..2^32-1.
REQ-002 Parameter REPEAT_CYCLES, default 10000000, cycles between auto-repeat events while held; legal range 2..2^32-1.
REQ-003 sysClk  input  1  system clock; all state changes on rising edge.
REQ-004 sysRst  input  1  reset; synchronous, active-high.
REQ-005 stableKey  input  2  debounced key levels, 1 = pressed; synchronous to sysClk.
REQ-006 evtReady  input  1  consumer accepts the head event when high with evtValid.
REQ-007 evtValid  output  1  head of event FIFO valid.
REQ-008 evtKey  output  1  key index of head event (0 or 1).
REQ-009 evtType  output  2  head event type: 00 press, 01 long, 10 repeat, 11 release.
REQ-010 overflow  output  1  sticky flag, set when any event is dropped.

Function
REQ-011 Block SHALL register stableKey into keyPrev each cycle; press edge = stableKey[i] & ~keyPrev[i], release edge = ~stableKey[i] & keyPrev[i].
REQ-012 Each key SHALL run an independent FSM with states IDLE, PRESSED, HELD and a 32-bit hold counter.
REQ-013 IDLE -> PRESSED on press edge: post press event, clear counter.
REQ-014 PRESSED: counter increments each cycle; when counter reaches LONG_CYCLES-1 -> HELD, post long event, clear counter.
REQ-015 HELD: counter increments each cycle; on reaching REPEAT_CYCLES-1 post repeat event, clear counter, remain in HELD.
REQ-016 PRESSED or HELD -> IDLE on release edge: post release event, clear counter; release overrides a long/repeat due in the same cycle (that event is not posted).
REQ-017 "Post" SHALL load the key's one-deep pending slot (key, type) at the same edge the FSM transitions.
REQ-018 If a key's pending slot is still occupied when a new event is posted, the new event SHALL be dropped, the slot kept, and overflow set.
REQ-019 Arbiter SHALL move at most one pending slot per cycle into a 4-entry FIFO when FIFO is not full; fixed priority key 0 over key 1.
REQ-020 A slot granted on edge k SHALL be free to accept a new post on the same edge k (no lost cycle).
REQ-021 FIFO full: pending slots hold; no drop occurs at the FIFO itself.
REQ-022 evtValid = FIFO not empty; evtKey/evtType driven from FIFO head; head pops on edge where evtValid & evtReady.
REQ-023 Simultaneous push and pop SHALL be allowed in any state, including full (count unchanged) and empty-with-bypass disallowed (an entry written on edge k is visible from edge k only, i.e. evtValid high after edge k).
REQ-024 Latency with empty FIFO and idle arbiter: input edge sampled at edge k -> slot loaded at k -> FIFO write at k+1 -> evtValid high after k+1.
REQ-025 FIFO pointers SHALL be 2 bits wrapping modulo 4, with a 3-bit count 0..4.
REQ-026 Outputs evtKey/evtType SHALL hold stable while evtValid high and evtReady low.

Reset
REQ-027 While sysRst high at an edge: FSMs -> IDLE, counters 0, keyPrev <= 2'b00, pending slots empty, FIFO pointers/count 0, overflow 0.
REQ-028 After reset: evtValid 0, evtKey 0, evtType 00.
REQ-029 A key already high when reset deasserts SHALL produce a press event (keyPrev reset to 0).
REQ-030 Reset mid-operation SHALL discard all queued and pending events with no partial output.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4, evtReady=1 unless stated)
REQ-031 Key0 high 3 cycles then low -> events (0,press) then (0,release), no long; overflow 0.
REQ-032 Key1 held 20 cycles -> (1,press); (1,long) 8 cycles after press; (1,repeat) every 4 cycles thereafter (2 repeats total); (1,release).
REQ-033 Both keys rise same cycle -> (0,press) at edge k+1, (1,press) at edge k+2.
REQ-034 evtReady=0, key0 toggled 6 times -> FIFO holds first 4 events, slot holds 1, later events dropped, overflow=1; raising evtReady drains 5 events in order.
REQ-035 Key0 held 10 cycles, sysRst pulsed 1 cycle -> evtValid 0 next cycle, overflow 0, a fresh (0,press) follows since key still high.
